// File: rtl/step_rate_seq.sv
// Converts a signed steps/s velocity into a step/dir pulse train, fetching
// each period as CLK_FREQ/|speed| from an external shared 32x32 divider.
module step_rate_seq #(
  parameter int CLK_FREQ    = 50000000,
  parameter int MIN_PERIOD  = 64,
  parameter int PULSE_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] in_speed,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_is_dividend_signed,
  output logic        div_is_truncate_16,
  input  logic [31:0] div_out,
  input  logic [1:0]  div_state,
  output logic        step,
  output logic        dir,
  output logic [31:0] period
);

  typedef enum logic [1:0] {D_IDLE, D_REQ, D_REL} dstate_e;

  localparam logic [1:0]  DS_IDLE = 2'd0;
  localparam logic [1:0]  DS_DONE = 2'd2;
  localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);
  localparam int          PW_W    = $clog2(PULSE_WIDTH + 1);
  localparam logic [PW_W-1:0] PW_LOAD = PW_W'(PULSE_WIDTH);

  dstate_e         state_q, state_d;
  logic            div_start_q, div_start_d;
  logic [31:0]     divisor_q, divisor_d;
  logic            samp_dir_q, samp_dir_d;
  logic [31:0]     nxt_period_q, nxt_period_d;
  logic            nxt_dir_q, nxt_dir_d;
  logic [31:0]     period_q, period_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            step_q, step_d;
  logic [PW_W-1:0] pw_q, pw_d;

  logic [31:0] abs_speed;
  logic        boundary;

  assign abs_speed = in_speed[31] ? (~in_speed + 32'd1) : in_speed;

  // The sign travels with the quotient so dir and period always switch together.
  always_comb begin
    state_d      = state_q;
    div_start_d  = div_start_q;
    divisor_d    = divisor_q;
    samp_dir_d   = samp_dir_q;
    nxt_period_d = nxt_period_q;
    nxt_dir_d    = nxt_dir_q;
    case (state_q)
      D_IDLE: begin
        if (enable && div_state == DS_IDLE) begin
          divisor_d  = abs_speed;
          samp_dir_d = in_speed[31];
          if (abs_speed == 32'd0) begin
            nxt_period_d = 32'd0;
          end else begin
            state_d     = D_REQ;
            div_start_d = 1'b1;
          end
        end
      end
      D_REQ: begin
        if (div_state == DS_DONE) begin
          nxt_period_d = (div_out < MIN_P) ? MIN_P : div_out;
          nxt_dir_d    = samp_dir_q;
          div_start_d  = 1'b0;
          state_d      = D_REL;
        end
      end
      D_REL: begin
        if (div_state == DS_IDLE) state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
    if (!enable) nxt_period_d = 32'd0;
  end

  assign boundary = (period_q == 32'd0) ? (nxt_period_q != 32'd0) : (cnt_q == 32'd0);

  // step is delayed one cycle behind the boundary so dir settles first.
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    pw_d     = pw_q;
    step_d   = (pw_q != '0);
    if (pw_q != '0) pw_d = pw_q - 1'b1;
    if (boundary) begin
      period_d = nxt_period_q;
      if (nxt_period_q != 32'd0) begin
        cnt_d = nxt_period_q - 32'd1;
        dir_d = nxt_dir_q;
        pw_d  = PW_LOAD;
      end else begin
        cnt_d = 32'd0;
      end
    end else if (period_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= D_IDLE;
      div_start_q  <= 1'b0;
      divisor_q    <= 32'd0;
      samp_dir_q   <= 1'b0;
      nxt_period_q <= 32'd0;
      nxt_dir_q    <= 1'b0;
      period_q     <= 32'd0;
      cnt_q        <= 32'd0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      pw_q         <= '0;
    end else begin
      state_q      <= state_d;
      div_start_q  <= div_start_d;
      divisor_q    <= divisor_d;
      samp_dir_q   <= samp_dir_d;
      nxt_period_q <= nxt_period_d;
      nxt_dir_q    <= nxt_dir_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      pw_q         <= pw_d;
    end
  end

  assign div_start              = div_start_q;
  assign div_dividend           = 32'(CLK_FREQ);
  assign div_divisor            = divisor_q;
  assign div_is_dividend_signed = 1'b0;
  assign div_is_truncate_16     = 1'b0;
  assign step                   = step_q;
  assign dir                    = dir_q;
  assign period                 = period_q;

endmodule

// File: tb/tb_step_rate_seq.sv
// Bench for step_rate_seq: behavioural multi-cycle divider plus a scoreboard of
// expected (period, dir) segments checked at each step-train transition.
module tb_step_rate_seq;

  localparam int CLK_FREQ    = 12800;
  localparam int MIN_PERIOD  = 64;
  localparam int PULSE_WIDTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] in_speed = 32'd0;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_is_dividend_signed;
  logic        div_is_truncate_16;
  logic [31:0] div_out;
  logic [1:0]  div_state;
  logic        step;
  logic        dir;
  logic [31:0] period;

  step_rate_seq #(
    .CLK_FREQ(CLK_FREQ), .MIN_PERIOD(MIN_PERIOD), .PULSE_WIDTH(PULSE_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_speed(in_speed),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_is_dividend_signed(div_is_dividend_signed),
    .div_is_truncate_16(div_is_truncate_16),
    .div_out(div_out), .div_state(div_state),
    .step(step), .dir(dir), .period(period)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider: idle -> busy 32 cycles -> complete, held until start is released.
  logic [1:0]  mdl_state = 2'd0;
  int          mdl_busy = 0;
  logic [31:0] mdl_den = 32'd1;
  logic [31:0] mdl_q = 32'd0;
  assign div_state = mdl_state;
  assign div_out   = mdl_q;

  always @(posedge clk) begin
    case (mdl_state)
      2'd0: if (div_start) begin
        mdl_state <= 2'd1;
        mdl_busy  <= 31;
        mdl_den   <= div_divisor;
      end
      2'd1: if (mdl_busy == 0) begin
        mdl_state <= 2'd2;
        mdl_q     <= (mdl_den == 32'd0) ? 32'hFFFF_FFFF : div_dividend / mdl_den;
      end else begin
        mdl_busy <= mdl_busy - 1;
      end
      default: if (!div_start) mdl_state <= 2'd0;
    endcase
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] per;
    logic        d;
  } exp_t;
  exp_t sb[$];

  task automatic expect_seg(input logic [31:0] p, input logic d);
    exp_t e;
    e.per = p;
    e.d   = d;
    sb.push_back(e);
  endtask

  logic        step_p = 1'b0, dir_p = 1'b0, start_p = 1'b0;
  logic [31:0] last_per = 32'd0;
  logic        last_dir = 1'b0;
  int          rise_cyc = 0;
  logic [31:0] rise_per = 32'd0;
  logic        rise_vld = 1'b0;
  int          hi_cnt = 0;
  int          c2 = 0;
  int          hs_bad = 0;
  logic        hs_en = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      step_p = 1'b0; dir_p = 1'b0; start_p = 1'b0;
      last_per = 32'd0; rise_vld = 1'b0; hi_cnt = 0; c2 = 0;
    end else begin
      if (step && !step_p) begin
        if (period !== last_per || dir !== last_dir) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $error("FAIL sb_underflow observed=period %0d dir %0d expected=no new segment", period, dir);
          end else begin
            e = sb.pop_front();
            check("seg_period", period, e.per);
            check("seg_dir", 32'(dir), 32'(e.d));
          end
          last_per = period;
          last_dir = dir;
        end
        check("dir_stable_before_step", 32'(dir), 32'(dir_p));
        if (rise_vld) check("step_interval", 32'(cyc - rise_cyc), rise_per);
        rise_vld = 1'b1;
        rise_cyc = cyc;
        rise_per = period;
      end
      if (last_per != 32'd0 && period == 32'd0) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $error("FAIL sb_underflow_stop observed=stop expected=no new segment");
        end else begin
          e = sb.pop_front();
          check("stop_period", period, e.per);
          check("stop_dir", 32'(dir), 32'(e.d));
        end
        last_per = 32'd0;
        rise_vld = 1'b0;
      end
      if (step) hi_cnt++;
      else if (step_p) begin
        check("pulse_width", 32'(hi_cnt), 32'(PULSE_WIDTH));
        hi_cnt = 0;
      end
      if (div_start && !start_p) check("start_rise_when_idle", 32'(div_state), 32'd0);
      if (hs_en && div_state == 2'd1 && !div_start) hs_bad++;
      if (div_state == 2'd2 && div_start) begin
        c2++;
        if (c2 > 1) hs_bad++;
      end else begin
        c2 = 0;
      end
      step_p  = step;
      dir_p   = dir;
      start_p = div_start;
    end
  end

  int quiet;

  initial begin
    rst = 1'b1; enable = 1'b0; in_speed = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_divisor", div_divisor, 32'd0);
    check("rst_period", period, 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    check("dividend", div_dividend, 32'd12800);
    check("tie_signed", 32'(div_is_dividend_signed), 32'd0);
    check("tie_trunc16", 32'(div_is_truncate_16), 32'd0);

    rst = 1'b0; enable = 1'b1; in_speed = 32'd100;
    expect_seg(32'd128, 1'b0);
    for (int i = 0; i < 20 && !div_start; i++) @(negedge clk);
    check("first_start", 32'(div_start), 32'd1);
    check("divisor_100", div_divisor, 32'd100);
    check("no_period_before_div", period, 32'd0);
    repeat (300) @(negedge clk);

    in_speed = -32'd200;
    expect_seg(32'd64, 1'b1);
    for (int i = 0; i < 60 && div_divisor != 32'd200; i++) @(negedge clk);
    check("divisor_neg200", div_divisor, 32'd200);
    repeat (300) @(negedge clk);

    in_speed = 32'd1000;
    expect_seg(32'd64, 1'b0);
    repeat (300) @(negedge clk);

    in_speed = 32'h8000_0000;
    expect_seg(32'd64, 1'b1);
    for (int i = 0; i < 60 && div_divisor != 32'h8000_0000; i++) @(negedge clk);
    check("divisor_min_int", div_divisor, 32'h8000_0000);
    repeat (300) @(negedge clk);

    in_speed = 32'd0;
    expect_seg(32'd0, 1'b1);
    for (int i = 0; i < 200 && period != 32'd0; i++) @(negedge clk);
    check("stopped_speed0", period, 32'd0);
    quiet = 0;
    repeat (100) begin
      @(negedge clk);
      if (step || div_start) quiet++;
    end
    check("quiet_speed0", 32'(quiet), 32'd0);

    in_speed = -32'd200;
    expect_seg(32'd64, 1'b1);
    repeat (300) @(negedge clk);
    enable = 1'b0;
    expect_seg(32'd0, 1'b1);
    for (int i = 0; i < 200 && period != 32'd0; i++) @(negedge clk);
    check("stopped_enable0", period, 32'd0);
    repeat (40) @(negedge clk);
    quiet = 0;
    repeat (100) begin
      @(negedge clk);
      if (step || div_start) quiet++;
    end
    check("quiet_enable0", 32'(quiet), 32'd0);

    enable = 1'b1; in_speed = 32'd100;
    expect_seg(32'd128, 1'b0);
    for (int i = 0; i < 400 && !(step && div_state == 2'd1); i++) @(negedge clk);
    check("pre_rst_busy", 32'(div_state), 32'd1);
    check("pre_rst_step", 32'(step), 32'd1);
    #2;
    hs_en = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_div_start", 32'(div_start), 32'd0);
    check("arst_divisor", div_divisor, 32'd0);
    check("arst_period", period, 32'd0);
    check("arst_step", 32'(step), 32'd0);
    check("arst_dir", 32'(dir), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60 && div_state != 2'd2; i++) @(negedge clk);
    check("post_rst_div_done", 32'(div_state), 32'd2);
    check("post_rst_no_period", period, 32'd0);
    expect_seg(32'd128, 1'b0);
    for (int i = 0; i < 60 && !div_start; i++) @(negedge clk);
    check("post_rst_restart", 32'(div_start), 32'd1);
    hs_en = 1'b1;
    repeat (400) @(negedge clk);

    enable = 1'b0;
    expect_seg(32'd0, 1'b0);
    for (int i = 0; i < 200 && period != 32'd0; i++) @(negedge clk);
    check("final_stop", period, 32'd0);
    repeat (50) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("handshake_violations", 32'(hs_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/step_rate_seq.md
STEP_RATE_SEQ -- requirements
Module: step_rate_seq

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, step-timer clock frequency in Hz (the division dividend).
REQ-002 SHALL have parameter MIN_PERIOD, default 64, minimum step period in clk cycles (must exceed 40).
REQ-003 SHALL have parameter PULSE_WIDTH, default 4, step high time in cycles (must be below MIN_PERIOD-1).
REQ-004 SHALL have port clk  in  1  the only clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  high = run; low = stop after the current period.
REQ-007 SHALL have port in_speed  in  32  signed velocity in steps/s.
REQ-008 SHALL have port div_start  out  1  start request to the 32x32 divider.
REQ-009 SHALL have port div_dividend  out  32  constant CLK_FREQ.
REQ-010 SHALL have port div_divisor  out  32  |speed| as sampled.
REQ-011 SHALL have port div_is_dividend_signed  out  1  tied 0.
REQ-012 SHALL have port div_is_truncate_16  out  1  tied 0.
REQ-013 SHALL have port div_out  in  32  divider quotient.
REQ-014 SHALL have port div_state  in  2  divider state: 0 idle, 1 busy, 2 complete.
REQ-015 SHALL have port step  out  1  step pulse.
REQ-016 SHALL have port dir  out  1  direction, 1 = negative speed.
REQ-017 SHALL have port period  out  32  active step period in cycles; 0 = stopped.

Function
REQ-018 Division FSM SHALL have states D_IDLE, D_REQ and D_REL.
REQ-019 D_IDLE with enable=1 and div_state=0 SHALL sample in_speed, then set div_divisor=|in_speed| as 32-bit unsigned (0x80000000 maps to 0x80000000) and nxt_dir=in_speed[31].
REQ-020 D_IDLE, sampled speed 0: SHALL set next_period=0 and remain in D_IDLE, resampling the next cycle without asserting div_start.
REQ-021 D_IDLE, sampled speed nonzero: SHALL go to D_REQ with div_start=1 registered.
REQ-022 D_REQ SHALL hold div_start=1 and div_divisor stable until div_state=2.
REQ-023 On div_state=2 in D_REQ: SHALL latch next_period=max(div_out, MIN_PERIOD), drop div_start and go to D_REL.
REQ-024 If enable=0 when div_out is latched, the result SHALL be discarded and next_period SHALL be set to 0.
REQ-025 D_REL SHALL keep div_start=0 until div_state=0, then return to D_IDLE; div_start SHALL never rise while div_state!=0.
REQ-026 Division SHALL repeat continuously while enable=1, so next_period tracks in_speed with about 36 cycles of lag.
REQ-027 enable=0 SHALL force next_period=0 on the next edge, regardless of the FSM state.
REQ-028 Step timer, stopped (period=0) and next_period!=0: on that edge SHALL load period=next_period, dir=nxt_dir and cnt=period-1; this edge is the boundary.
REQ-029 Step timer, running: cnt SHALL decrement each cycle; when cnt=0 the edge is a boundary that reloads period, dir and cnt from next_period.
REQ-030 If next_period=0 at a boundary: SHALL set period=0, with no further pulse and dir held.
REQ-031 step SHALL be high for exactly PULSE_WIDTH cycles, starting one cycle after each boundary; dir SHALL change only at a boundary, so it is stable at least 1 cycle before step rises.
REQ-032 A speed change mid-period SHALL take effect only at the next boundary, with no truncated or stretched period.
REQ-033 Sign reversal SHALL update dir and period at the same boundary.

Reset
REQ-034 rst=1 SHALL immediately force D_IDLE, div_start=0, div_divisor=0, next_period=0, period=0, cnt=0, step=0 and dir=0.
REQ-035 Asserting rst mid-division or mid-pulse SHALL abort without completing either; after release, the FSM SHALL wait in D_IDLE for div_state=0 before restarting.
REQ-036 After rst release, the first step SHALL occur only after a completed division.

Verification
REQ-037 CLK_FREQ=12800, speed=+100, enable=1 -> div_divisor=100, period=128, step 4 cycles high every 128 cycles, dir=0.
REQ-038 Speed changes from +100 to -200 mid-period -> current 128-cycle period completes; next boundary gives period=64, dir=1, and dir is stable 1 cycle before step rises.
REQ-039 speed=+1000 (quotient 12) -> period clamps to 64.
REQ-040 Handshake check -> div_start held through div_state=1, falls within 1 cycle of div_state=2, and does not rise again until div_state=0.
REQ-041 enable=0 or speed=0 mid-period -> the period finishes, then period=0, step stays 0 and div_start stays 0 (enable=0 case).
REQ-042 rst pulsed while div_state=1 -> all outputs are 0 in the same cycle; after release, no div_start until div_state=0.
